// File: rtl/accum_core.sv
// accum_core: multi-cycle accumulator processor core.
// BOOT -> FETCH -> EXEC [-> MEM] -> FETCH ... with a req/ack memory port.
// All memory-port outputs and halted are registered, so an asynchronous reset
// drops mem_req in the same instant it is asserted.
module accum_core #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned HALT_REG   = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc
);
    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;
    localparam int unsigned FieldW  = DATA_W - 3;
    localparam logic [REG_ADDR_W-1:0] HaltIdx = REG_ADDR_W'(HALT_REG);

    localparam logic [2:0] OpLda = 3'b000;
    localparam logic [2:0] OpLdi = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpLw  = 3'b100;
    localparam logic [2:0] OpSw  = 3'b101;
    localparam logic [2:0] OpBnz = 3'b110;
    localparam logic [2:0] OpHlt = 3'b111;

    typedef enum logic [2:0] {StBoot, StFetch, StExec, StMem, StHalt} state_e;

    state_e                           state_q;
    logic [DATA_W-1:0]                ir_q;
    logic [NumRegs-1:0][DATA_W-1:0]   regs_q;

    logic [2:0]            op;
    logic [FieldW-1:0]     f;
    logic [REG_ADDR_W-1:0] r;
    logic [DATA_W-1:0]     r_val;
    logic [DATA_W-1:0]     ldi_val;
    logic [DATA_W-1:0]     alu_val;
    logic [ADDR_W-1:0]     exec_pc;
    logic                  exec_halt;
    logic                  lw_halt;

    assign op      = ir_q[DATA_W-1 -: 3];
    assign f       = ir_q[FieldW-1:0];
    assign r       = f[REG_ADDR_W-1:0];
    assign r_val   = regs_q[r];
    assign ldi_val = {{3{f[FieldW-1]}}, f};

    // Execute-stage results: ALU value, next fetch address and halt-register detection.
    always_comb begin
        alu_val   = (op == OpSub) ? (acc - r_val) : (acc + r_val);
        exec_pc   = ((op == OpBnz) && (acc != '0)) ? r_val[ADDR_W-1:0] : pc;
        exec_halt = (op == OpHlt) ||
                    (((op == OpAdd) || (op == OpSub)) && (r == HaltIdx) && (alu_val != '0));
        // Only meaningful in MEM for a load; mem_we is 0 exactly for LW there.
        lw_halt   = !mem_we && (r == HaltIdx) && (mem_rdata != '0);
    end

    // Sequencer: state, architectural registers and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StBoot;
            ir_q      <= '0;
            regs_q    <= '0;
            pc        <= '0;
            acc       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q  <= StFetch;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                StFetch: begin
                    if (mem_ack) begin
                        ir_q    <= mem_rdata;
                        pc      <= pc + 1'b1;
                        mem_req <= 1'b0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    unique case (op)
                        OpLda:        acc       <= r_val;
                        OpLdi:        acc       <= ldi_val;
                        OpAdd, OpSub: regs_q[r] <= alu_val;
                        OpBnz:        pc        <= exec_pc;
                        default:      ;
                    endcase
                    if ((op == OpLw) || (op == OpSw)) begin
                        state_q   <= StMem;
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OpSw);
                        mem_addr  <= acc[ADDR_W-1:0];
                        mem_wdata <= r_val;
                    end else if (exec_halt) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                    end else begin
                        state_q  <= StFetch;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= exec_pc;
                    end
                end
                StMem: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            regs_q[r] <= mem_rdata;
                        end
                        mem_we <= 1'b0;
                        if (lw_halt) begin
                            state_q <= StHalt;
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            // Straight into the next fetch: LW/SW take three cycles.
                            state_q  <= StFetch;
                            mem_addr <= pc;
                        end
                    end
                end
                StHalt: begin
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                end
                default: state_q <= StBoot;
            endcase
        end
    end

endmodule
